// File: rtl/sseg_scan_bcd.sv
// rtl/sseg_scan_bcd.sv - binary load, double-dabble BCD conversion, multiplexed seven-segment scan
// Display register only changes on a finished conversion; the scan runs freely from it.
module sseg_scan_bcd #(
   parameter int DIGITS      = 4,
   parameter int DATA_W      = 13,
   parameter int REFRESH_DIV = 50000,
   parameter int BLANK_LZ    = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [DATA_W-1:0] data,
   output logic              busy,
   output logic [7:0]        sseg,
   output logic [DIGITS-1:0] an
);

   // Decimal digit count of the largest input value, never fewer than the anodes.
   function automatic int calc_bcd_n(input int w, input int digs);
      longint v;
      int     n;
      v = (longint'(1) << w) - 1;
      n = 0;
      while (v > 0) begin
         v = v / 10;
         n = n + 1;
      end
      if (n < digs) n = digs;
      return n;
   endfunction

   function automatic logic [7:0] glyph(input logic [3:0] nib);
      case (nib)
         4'd0:    glyph = 8'b10000001;
         4'd1:    glyph = 8'b11001111;
         4'd2:    glyph = 8'b10010010;
         4'd3:    glyph = 8'b10000110;
         4'd4:    glyph = 8'b11001100;
         4'd5:    glyph = 8'b10100100;
         4'd6:    glyph = 8'b10100000;
         4'd7:    glyph = 8'b10001111;
         4'd8:    glyph = 8'b10000000;
         4'd9:    glyph = 8'b10000100;
         default: glyph = 8'b11111111;
      endcase
   endfunction

   localparam int BCD_N = calc_bcd_n(DATA_W, DIGITS);
   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam int RW    = $clog2(REFRESH_DIV);
   localparam int IW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
   localparam logic [RW-1:0]    RCNT_MAX = RW'(REFRESH_DIV - 1);
   localparam logic [IW-1:0]    IDX_MAX  = IW'(DIGITS - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [DATA_W-1:0]       bin_q, bin_d;
   logic [4*BCD_N-1:0]      bcd_q, bcd_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [4*DIGITS-1:0]     disp_q, disp_d;
   logic                    ovf_q, ovf_d;
   logic [RW-1:0]           rcnt_q, rcnt_d;
   logic [IW-1:0]           idx_q, idx_d;
   logic [DIGITS-1:0]       an_q, an_d;
   logic [7:0]              sseg_q, sseg_d;

   logic [4*BCD_N-1:0]      adj;
   logic                    ovf_any;
   logic [DIGITS-1:0]       upper_zero;
   logic                    zacc;
   logic [3:0]              cur_nib;

   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      bcd_d   = bcd_q;
      cnt_d   = cnt_q;
      disp_d  = disp_q;
      ovf_d   = ovf_q;
      adj     = bcd_q;
      ovf_any = 1'b0;

      for (int i = 0; i < BCD_N; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
      for (int i = DIGITS; i < BCD_N; i++) begin
         ovf_any = ovf_any | (|bcd_q[4*i +: 4]);
      end

      case (state_q)
         S_IDLE: begin
            if (load) begin
               bin_d   = data;
               bcd_d   = '0;
               cnt_d   = '0;
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            bcd_d = {adj[4*BCD_N-2:0], bin_q[DATA_W-1]};
            bin_d = bin_q << 1;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) state_d = S_DONE;
         end
         S_DONE: begin
            disp_d  = bcd_q[4*DIGITS-1:0];
            ovf_d   = ovf_any;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      rcnt_d     = rcnt_q + RW'(1);
      idx_d      = idx_q;
      upper_zero = '0;
      zacc       = 1'b1;

      if (rcnt_q == RCNT_MAX) begin
         rcnt_d = '0;
         idx_d  = (idx_q == IDX_MAX) ? '0 : idx_q + IW'(1);
      end

      // upper_zero[i]: nibbles i..DIGITS-1 are all zero, i.e. digit i is a leading zero.
      for (int i = DIGITS - 1; i >= 0; i--) begin
         zacc          = zacc & (disp_q[4*i +: 4] == 4'd0);
         upper_zero[i] = zacc;
      end

      cur_nib = disp_q[4*int'(idx_q) +: 4];
      an_d    = ~(DIGITS'(1) << idx_q);

      if (ovf_q)
         sseg_d = 8'b11111110;
      else if ((BLANK_LZ != 0) && (idx_q != '0) && upper_zero[idx_q])
         sseg_d = 8'b11111111;
      else
         sseg_d = glyph(cur_nib);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         bin_q   <= '0;
         bcd_q   <= '0;
         cnt_q   <= '0;
         disp_q  <= '0;
         ovf_q   <= 1'b0;
         rcnt_q  <= '0;
         idx_q   <= '0;
         an_q    <= '1;
         sseg_q  <= 8'hFF;
      end else begin
         state_q <= state_d;
         bin_q   <= bin_d;
         bcd_q   <= bcd_d;
         cnt_q   <= cnt_d;
         disp_q  <= disp_d;
         ovf_q   <= ovf_d;
         rcnt_q  <= rcnt_d;
         idx_q   <= idx_d;
         an_q    <= an_d;
         sseg_q  <= sseg_d;
      end
   end

   assign busy = (state_q != S_IDLE);
   assign sseg = sseg_q;
   assign an   = an_q;

endmodule
